// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   pwm_mode_e : period alignment mode (edge or center aligned)
//   pwm_dir_e  : timebase counting direction
//   pwm_max()  : full-scale duty value for a given counter width
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Full-scale duty M = 2**width - 1
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle for pwm_multi.
//   enable, center_mode, prescale : run control and timebase configuration
//   level_wr, level_in            : duty write strobe and packed per-channel duty
//   out, period_start, update_pend: PWM outputs and status (driven by the generator)
// master = controller side, slave = PWM generator side.
interface pwm_multi_if #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
);

  logic                      enable;
  logic                      center_mode;
  logic [PRESCALE_W-1:0]     prescale;
  logic                      level_wr;
  logic [CHANNELS*WIDTH-1:0] level_in;
  logic [CHANNELS-1:0]       out;
  logic                      period_start;
  logic                      update_pend;

  modport master (
    output enable, center_mode, prescale, level_wr, level_in,
    input  out, period_start, update_pend
  );

  modport slave (
    input  enable, center_mode, prescale, level_wr, level_in,
    output out, period_start, update_pend
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter and direction.
//   clk, reset_n : clock and async active-low reset
//   enable       : 0 holds prescaler/counter/direction at 0/0/up
//   mode         : active alignment mode (edge or center)
//   prescale     : counter advances every prescale+1 clocks
//   count        : current counter value (registered)
//   running      : timebase has passed its start boundary (registered)
//   boundary_c   : this cycle starts a new period at the next edge
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  pwm_mode_e             mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  boundary_c
);

  // Last counter value of the up phase (M-1)
  localparam logic [WIDTH-1:0] TOP = WIDTH'(pwm_max(WIDTH) - 32'd1);

  logic [PRESCALE_W-1:0] presc_cnt;
  pwm_dir_e              dir;
  logic                  tick_c;
  logic                  wrap_c;

  // Tick and period-boundary detection; the first enabled cycle is itself a boundary
  always_comb begin
    tick_c     = 1'b0;
    wrap_c     = 1'b0;
    boundary_c = 1'b0;
    if (enable && running) begin
      // >= keeps a shrinking prescale from running the prescaler up to overflow
      tick_c = (presc_cnt >= prescale);
      if (mode == PWM_CENTER) begin
        wrap_c = (dir == DIR_DOWN) && (count == '0);
      end else begin
        wrap_c = (count == TOP);
      end
      boundary_c = tick_c && wrap_c;
    end else if (enable) begin
      boundary_c = 1'b1;
    end
  end

  // Prescaler, counter and direction state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      count     <= '0;
      dir       <= DIR_UP;
      running   <= 1'b0;
    end else if (!enable || !running) begin
      presc_cnt <= '0;
      count     <= '0;
      dir       <= DIR_UP;
      running   <= enable;
    end else if (tick_c) begin
      presc_cnt <= '0;
      if (mode == PWM_CENTER) begin
        // Each end value is held for two ticks while the direction flips
        if (dir == DIR_UP) begin
          if (count == TOP) dir <= DIR_DOWN;
          else              count <= count + WIDTH'(1);
        end else begin
          if (count == '0) dir <= DIR_UP;
          else             count <= count - WIDTH'(1);
        end
      end else begin
        dir   <= DIR_UP;
        count <= wrap_c ? '0 : count + WIDTH'(1);
      end
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared timebase and double-buffered duty.
//   clk, reset_n : clock and async active-low reset
//   bus (slave)  : enable/center_mode/prescale/level_wr/level_in in,
//                  out/period_start/update_pend out (all registered)
// Duty and alignment mode written mid-period only take effect at the next
// period boundary, so outputs never glitch on an update.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned         CHANNELS    = 3,
  parameter int unsigned         WIDTH       = 8,
  parameter int unsigned         PRESCALE_W  = 8,
  parameter logic [CHANNELS-1:0] INVERT_MASK = '0
) (
  input logic        clk,
  input logic        reset_n,
  pwm_multi_if.slave bus
);

  logic [CHANNELS-1:0][WIDTH-1:0] pending;
  logic [CHANNELS-1:0][WIDTH-1:0] active;
  pwm_mode_e                      active_mode;
  logic                           update_pend;
  logic                           period_start;
  logic [CHANNELS-1:0]            out_q;
  logic [CHANNELS-1:0]            raw_c;
  logic [WIDTH-1:0]               count;
  logic                           running;
  logic                           boundary_c;
  logic                           run_c;

  pwm_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (bus.enable),
    .mode       (active_mode),
    .prescale   (bus.prescale),
    .count      (count),
    .running    (running),
    .boundary_c (boundary_c)
  );

  // Disabling forces idle on the very next edge, without waiting for running to drop
  assign run_c = bus.enable && running;

  // Pending/active duty buffers; a write on the boundary cycle stays pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      active       <= '0;
      active_mode  <= PWM_EDGE;
      update_pend  <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary_c;
      if (boundary_c) begin
        active      <= pending;
        active_mode <= pwm_mode_e'(bus.center_mode);
      end
      if (bus.level_wr) begin
        pending     <= bus.level_in;
        update_pend <= 1'b1;
      end else if (boundary_c) begin
        update_pend <= 1'b0;
      end
    end
  end

  // Per-channel comparators
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign raw_c[i] = run_c && (count < active[i]);
  end

  // Registered outputs with per-channel polarity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= INVERT_MASK;
    else          out_q <= raw_c ^ INVERT_MASK;
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start;
  assign bus.update_pend  = update_pend;

endmodule
